// File: rtl/rpn_stack_sequencer_if.sv
// Command/response channel between a requester and the RPN stack sequencer.
// The requester drives commands and receives one completion pulse per command.
interface rpn_stack_sequencer_if #(
    parameter int unsigned BUS_WIDTH = 16
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [BUS_WIDTH-1:0] cmd_imm;
    logic                 res_valid;
    logic                 res_err;
    logic [BUS_WIDTH-1:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_imm,
        input  cmd_ready, res_valid, res_err, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm,
        output cmd_ready, res_valid, res_err, res_data
    );
endinterface

// File: rtl/rpn_stack_sequencer.sv
// Sequences RPN commands (push/dup/drop/binary ALU) onto an attached push/pop stack,
// tracking depth locally so underflow/overflow commands are rejected before any strobe.
module rpn_stack_sequencer #(
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned STACK_SIZE = 16,
    localparam int unsigned DEPTH_W   = $clog2(STACK_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    rpn_stack_sequencer_if.slave cmd,
    output logic [DEPTH_W-1:0]   depth,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [BUS_WIDTH-1:0] stk_wdata,
    input  logic [BUS_WIDTH-1:0] stk_top
);

    typedef enum logic [2:0] {
        IDLE, RD_B, WT, RD_A, EXEC, WR, SETTLE, DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_PUSH = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_DUP  = 3'b110,
        OP_DROP = 3'b111
    } op_e;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [BUS_WIDTH-1:0] opa_q, opa_d;
    logic [BUS_WIDTH-1:0] opb_q, opb_d;
    logic [BUS_WIDTH-1:0] result_q, result_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_err_q, res_err_d;
    logic [BUS_WIDTH-1:0] res_data_q, res_data_d;
    logic                 stk_push_q, stk_push_d;
    logic                 stk_pop_q, stk_pop_d;
    logic [BUS_WIDTH-1:0] stk_wdata_q, stk_wdata_d;

    logic                 legal_c;
    logic [BUS_WIDTH-1:0] alu_c;

    // Acceptance-time legality against the locally tracked depth.
    always_comb begin
        legal_c = 1'b0;
        unique case (op_e'(cmd.cmd_op))
            OP_PUSH: legal_c = (depth_q < DEPTH_W'(STACK_SIZE));
            OP_DUP:  legal_c = (depth_q >= DEPTH_W'(1)) && (depth_q < DEPTH_W'(STACK_SIZE));
            OP_DROP: legal_c = (depth_q >= DEPTH_W'(1));
            default: legal_c = (depth_q >= DEPTH_W'(2));
        endcase
    end

    // A is the deeper entry, so SUB is A - B.
    always_comb begin
        alu_c = opb_q;
        unique case (op_q)
            OP_ADD:  alu_c = opa_q + opb_q;
            OP_SUB:  alu_c = opa_q - opb_q;
            OP_AND:  alu_c = opa_q & opb_q;
            OP_OR:   alu_c = opa_q | opb_q;
            OP_XOR:  alu_c = opa_q ^ opb_q;
            default: alu_c = opb_q;
        endcase
    end

    // Outputs are set on the edge entering the state they belong to.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        depth_d     = depth_q + DEPTH_W'(stk_push_q) - DEPTH_W'(stk_pop_q);
        cmd_ready_d = 1'b0;
        res_valid_d = 1'b0;
        res_err_d   = 1'b0;
        res_data_d  = '0;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        stk_wdata_d = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd.cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = op_e'(cmd.cmd_op);
                    if (!legal_c) begin
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                    end else begin
                        unique case (op_e'(cmd.cmd_op))
                            OP_PUSH: begin
                                state_d     = WR;
                                result_d    = cmd.cmd_imm;
                                stk_push_d  = 1'b1;
                                stk_wdata_d = cmd.cmd_imm;
                            end
                            OP_DUP:  state_d = RD_B;
                            default: begin
                                state_d   = RD_B;
                                stk_pop_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            RD_B: begin
                opb_d = stk_top;
                if (op_q == OP_DUP) begin
                    state_d = EXEC;
                end else if (op_q == OP_DROP) begin
                    state_d = SETTLE;
                end else begin
                    state_d = WT;
                end
            end
            WT: begin
                state_d   = RD_A;
                stk_pop_d = 1'b1;
            end
            RD_A: begin
                opa_d   = stk_top;
                state_d = EXEC;
            end
            EXEC: begin
                result_d    = alu_c;
                state_d     = WR;
                stk_push_d  = 1'b1;
                stk_wdata_d = alu_c;
            end
            WR: state_d = SETTLE;
            SETTLE: begin
                state_d     = DONE;
                res_valid_d = 1'b1;
                res_data_d  = (op_q == OP_DROP) ? opb_q : result_q;
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_PUSH;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            depth_q     <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            stk_push_q  <= 1'b0;
            stk_pop_q   <= 1'b0;
            stk_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            depth_q     <= depth_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            res_data_q  <= res_data_d;
            stk_push_q  <= stk_push_d;
            stk_pop_q   <= stk_pop_d;
            stk_wdata_q <= stk_wdata_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.res_valid = res_valid_q;
    assign cmd.res_err   = res_err_q;
    assign cmd.res_data  = res_data_q;
    assign depth         = depth_q;
    assign stk_push      = stk_push_q;
    assign stk_pop       = stk_pop_q;
    assign stk_wdata     = stk_wdata_q;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Bench for rpn_stack_sequencer: directed scenarios plus random commands checked
// against a queue-based RPN model; a registered-top stack model is attached to the DUT.
module tb_rpn_stack_sequencer;

    localparam int unsigned BW = 16;
    localparam int unsigned SS = 16;
    localparam int unsigned DW = $clog2(SS) + 1;

    localparam logic [2:0] PUSH = 3'b000, ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011,
                           OR_  = 3'b100, XOR_ = 3'b101, DUP = 3'b110, DROP = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] depth;
    logic          stk_push, stk_pop;
    logic [BW-1:0] stk_wdata;
    logic [BW-1:0] stk_top;

    rpn_stack_sequencer_if #(.BUS_WIDTH(BW)) bus ();

    rpn_stack_sequencer #(.BUS_WIDTH(BW), .STACK_SIZE(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (bus),
        .depth     (depth),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_top   (stk_top)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Attached stack: strobe in cycle N shows on stk_top in cycle N+1.
    logic [BW-1:0] stk_mem[$];
    always @(posedge clk) begin
        if (reset) begin
            stk_mem.delete();
            stk_top <= '0;
        end else if (stk_push) begin
            stk_mem.push_back(stk_wdata);
            stk_top <= stk_wdata;
        end else if (stk_pop) begin
            if (stk_mem.size() > 0) void'(stk_mem.pop_back());
            stk_top <= (stk_mem.size() > 0) ? stk_mem[$] : '0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("push_pop_excl", 32'(stk_push & stk_pop), 32'd0);
            if (!stk_push) check("wdata_zero_idle", 32'(stk_wdata), 32'd0);
        end
    end

    // Reference RPN stack.
    logic [BW-1:0] ref_stk[$];

    // Issue one command (caller sits at a negedge) and check its full response.
    task automatic run_cmd(input logic [2:0] op, input logic [BW-1:0] imm);
        int d;
        bit legal;
        logic [BW-1:0] a, b, v;
        int exp_lat, exp_push, exp_pop, lat, n_push, n_pop, w;
        d = ref_stk.size();
        case (op)
            PUSH:    legal = d < SS;
            DUP:     legal = d >= 1 && d < SS;
            DROP:    legal = d >= 1;
            default: legal = d >= 2;
        endcase
        v = '0;
        if (!legal) begin
            exp_lat = 1; exp_push = 0; exp_pop = 0;
        end else if (op == PUSH) begin
            v = imm; ref_stk.push_back(v);
            exp_lat = 3; exp_push = 1; exp_pop = 0;
        end else if (op == DUP) begin
            v = ref_stk[$]; ref_stk.push_back(v);
            exp_lat = 5; exp_push = 1; exp_pop = 0;
        end else if (op == DROP) begin
            v = ref_stk.pop_back();
            exp_lat = 3; exp_push = 0; exp_pop = 1;
        end else begin
            b = ref_stk.pop_back();
            a = ref_stk.pop_back();
            case (op)
                ADD:     v = a + b;
                SUB:     v = a - b;
                AND_:    v = a & b;
                OR_:     v = a | b;
                default: v = a ^ b;
            endcase
            ref_stk.push_back(v);
            exp_lat = 7; exp_push = 1; exp_pop = 2;
        end

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_imm   = BW'($urandom);

        n_push = 0; n_pop = 0;
        for (lat = 1; lat <= 12; lat++) begin
            @(negedge clk);
            n_push += int'(stk_push);
            n_pop  += int'(stk_pop);
            if (bus.res_valid === 1'b1) break;
        end
        check("latency",   32'(lat), 32'(exp_lat));
        check("res_err",   32'(bus.res_err), 32'(!legal));
        check("res_data",  32'(bus.res_data), 32'(v));
        check("depth",     32'(depth), 32'(ref_stk.size()));
        check("push_cnt",  32'(n_push), 32'(exp_push));
        check("pop_cnt",   32'(n_pop), 32'(exp_pop));
        check("stk_top",   32'(stk_top), (ref_stk.size() > 0) ? 32'(ref_stk[$]) : 32'd0);
    endtask

    initial begin
        logic [2:0] op;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_imm   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_err",   32'(bus.res_err), 32'd0);
        check("rst_res_data",  32'(bus.res_data), 32'd0);
        check("rst_depth",     32'(depth), 32'd0);
        check("rst_push",      32'(stk_push), 32'd0);
        check("rst_pop",       32'(stk_pop), 32'd0);
        check("rst_wdata",     32'(stk_wdata), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Push/sub, including modular wrap.
        run_cmd(PUSH, 16'h0005);
        run_cmd(PUSH, 16'h0003);
        run_cmd(SUB,  16'h0000);
        run_cmd(DROP, 16'h0000);
        run_cmd(PUSH, 16'h0003);
        run_cmd(PUSH, 16'h0005);
        run_cmd(SUB,  16'h0000);
        run_cmd(DROP, 16'h0000);

        // Underflow rejections.
        run_cmd(DROP, 16'h0000);
        run_cmd(PUSH, 16'h0001);
        run_cmd(ADD,  16'h0000);
        run_cmd(DROP, 16'h0000);

        // Fill to capacity, then overflow rejections.
        for (int i = 0; i < 16; i++) run_cmd(PUSH, 16'(i));
        run_cmd(PUSH, 16'h1234);
        run_cmd(DUP,  16'h0000);
        run_cmd(DROP, 16'h0000);
        for (int i = 0; i < 15; i++) run_cmd(DROP, 16'h0000);

        run_cmd(PUSH, 16'h00F0);
        run_cmd(DUP,  16'h0000);
        run_cmd(XOR_, 16'h0000);
        run_cmd(DROP, 16'h0000);

        // Random command stream.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) op = PUSH;
            else op = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_cmd(op, 16'($urandom));
        end

        // Reset during EXEC of an ADD aborts it silently.
        run_cmd(PUSH, 16'h0001);
        run_cmd(PUSH, 16'h0002);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = ADD;
        bus.cmd_imm   = '0;
        for (int w = 0; w < 20 && bus.cmd_ready !== 1'b1; w++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("abort_no_res_pre", 32'(bus.res_valid), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_stk.delete();
        check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_depth",     32'(depth), 32'd0);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_push",      32'(stk_push), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("abort_no_res_post", 32'(bus.res_valid), 32'd0);
        end
        run_cmd(PUSH, 16'h00AA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
